spi_crypto_master: RTL
======================

// Module: spi_crypto_master
// PURPOSE
//  Parametrised SPI-style master between host registers and the AES enc/dec slaves.
//  On start it selects one of NSLV slaves and shifts out {message, key} MSB-first.
//  It then waits a turnaround gap, shifts in the 128-bit result and presents it with a done pulse.
//  Adds, over the previous master: start/busy/done handshake, divided sclk, multi-slave select, key-size generics.
// PARAMETERS
//  NK         8  key length in 32-bit words (4/6/8 -> AES-128/192/256)
//  NB         4  block length in 32-bit words; message and result are 32*NB bits
//  NSLV       2  number of slaves / chip selects (0 = encryptor, 1 = decryptor)
//  CLK_DIV    2  sclk half-period in in_clk cycles, >=1
//  TURNAROUND 1  idle sclk bit-periods between last TX bit and first RX bit, >=0
// PORTS
//  in_clk   in   1          system clock; sclk derived from it
//  rst      in   1          synchronous active-high reset
//  start    in   1          request transaction; sampled only in IDLE
//  sel      in   SW         slave index, SW=max(1,$clog2(NSLV)); latched on start
//  msg_in   in   32*NB      plaintext/ciphertext; latched on start
//  key_in   in   32*NK      key; latched on start
//  sclk     out  1          serial clock, idle low (SPI mode 0)
//  cs_n     out  NSLV       active-low chip selects, one-hot-low while active
//  mosi     out  1          serial data to slave
//  miso     in   1          serial data from slave
//  busy     out  1          transaction in progress
//  done     out  1          one-cycle pulse, result valid
//  err      out  1          one-cycle pulse, start with sel>=NSLV rejected
//  result   out  32*NB      last received block, held until next done
// BEHAVIOUR
//  Reset (sync, any state): sclk=0, cs_n=all 1, mosi=0, busy=0, done=0, err=0, result=0, state=IDLE.
//  TX_BITS=32*NB+32*NK, RX_BITS=32*NB; BP = 2*CLK_DIV in_clk cycles per bit.
//  FSM: IDLE -> SETUP -> TX -> TURN -> RX -> FINISH -> IDLE.
//  IDLE: on the edge where start=1 and sel<NSLV: latch {msg_in,key_in} into PISO, latch sel.
//   Go to SETUP with busy=1. If sel>=NSLV: err=1 for one cycle, stay IDLE.
//  SETUP (1 cycle): cs_n[sel]=0, mosi=PISO MSB (msg_in[32*NB-1]), sclk=0.
//  TX: each bit = CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1.
//   mosi changes only when sclk falls (next bit) and is stable across each rising edge.
//   After the falling edge of bit TX_BITS-1, mosi=0 and go to TURN (or RX if TURNAROUND=0).
//  TURN: sclk held 0 for TURNAROUND*BP cycles, cs_n stays asserted.
//  RX: sclk toggles as in TX; miso is sampled on the in_clk edge where sclk goes 0->1.
//   Samples are shifted into SIPO LSB, first sample ends up as result MSB.
//   After RX_BITS samples, the sclk high phase completes, sclk returns 0, then FINISH.
//  FINISH (1 cycle): result<=SIPO, done=1, cs_n all 1; busy=0 from next cycle.
//  Total: start edge to done = 2 + (TX_BITS+TURNAROUND+RX_BITS)*BP cycles.
//  start while busy: ignored (no queueing). start same cycle as done: ignored; re-request in IDLE.
//  Changes on msg_in/key_in/sel after latch do not affect the running transaction.
//  Reset mid-transaction aborts immediately: no done, result cleared, cs_n released same edge.
//  Bit counters sized $clog2(TX_BITS+1); no wrap within a frame; sclk never glitches (registered).
//  mosi is never tri-stated; driven 0 outside TX.
// TESTING
//  T1 NK=4,CLK_DIV=1,TURNAROUND=1, slave model echoes msg: start,sel=0,msg=128'h00112233_44556677_8899AABB_CCDDEEFF
//   -> cs_n=2'b10, 256 mosi bits = msg then key, done at start+2+(256+1+128)*2=772 cycles, result=msg.
//  T2 sel=1, miso tied 1 -> cs_n=2'b01 only, result=128'hFFFF...FF, one done pulse, busy falls cycle after done.
//  T3 start pulsed again at cycle 100 of a running transaction -> ignored; exactly one done, result unchanged by the second start.
//  T4 rst asserted mid-TX (bit 40) -> next edge sclk=0, cs_n=all 1, busy=0, result=0; no done. New start then completes normally.
//  T5 NSLV=2, sel=1'b1 valid; NSLV=3 with sel=2'd3 -> err pulse 1 cycle, busy stays 0, cs_n stays all 1.
//  T6 CLK_DIV=3,NK=8 -> sclk high/low 3 cycles each, 384 TX + 128 RX rising edges, mosi stable across every rising edge.

Source files
------------

// File: rtl/spi_crypto_master.sv
// spi_crypto_master: SPI mode-0 master that shifts {msg,key} out to one AES slave and shifts the result block back in
module spi_crypto_master #(
    parameter int NK = 8,
    parameter int NB = 4,
    parameter int NSLV = 2,
    parameter int CLK_DIV = 2,
    parameter int TURNAROUND = 1,
    localparam int SW = (NSLV > 2) ? $clog2(NSLV) : 1
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    sel,
    input  logic [32*NB-1:0] msg_in,
    input  logic [32*NK-1:0] key_in,
    output logic             sclk,
    output logic [NSLV-1:0]  cs_n,
    output logic             mosi,
    input  logic             miso,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [32*NB-1:0] result
);
    localparam int TXB = 32 * (NB + NK);
    localparam int RXB = 32 * NB;
    localparam int BP = 2 * CLK_DIV;
    localparam int CW = $clog2(TXB + 1);
    localparam int PW = $clog2(BP);
    localparam int TURN_LAST = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
    typedef enum logic [2:0] {IDLE, SETUP, TX, TURN, RX, FINISH} state_t;
    state_t state, nxt;
    logic [PW-1:0] ph;
    logic [CW-1:0] bits;
    logic [TXB-1:0] piso;
    logic [RXB-1:0] sipo;
    logic [NSLV-1:0] cs_sel;
    logic valid, launch, rise, bit_end, last_bit, shifting;
    assign busy = state != IDLE;
    always_comb begin
        valid = 32'(sel) < NSLV;
        launch = state == IDLE && start && valid;
        rise = ph == PW'(CLK_DIV - 1);
        bit_end = ph == PW'(BP - 1);
        last_bit = bits == CW'(state == TX ? TXB - 1 : state == TURN ? TURN_LAST : RXB - 1);
        shifting = state == TX || state == TURN || state == RX;
        for (int i = 0; i < NSLV; i++) cs_sel[i] = 32'(sel) != i;
        nxt = state;
        case (state)
            IDLE:    nxt = launch ? SETUP : IDLE;
            SETUP:   nxt = TX;
            TX:      nxt = bit_end && last_bit ? (TURNAROUND > 0 ? TURN : RX) : TX;
            TURN:    nxt = bit_end && last_bit ? RX : TURN;
            RX:      nxt = bit_end && last_bit ? FINISH : RX;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge in_clk) state <= rst ? IDLE : nxt;
    always_ff @(posedge in_clk) begin
        if (rst) begin
            sclk <= 1'b0;
            cs_n <= '1;
            mosi <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            result <= '0;
            ph <= '0;
            bits <= '0;
        end else begin
            err <= state == IDLE && start && !valid;
            done <= state == RX && nxt == FINISH;
            if (launch) begin
                piso <= {msg_in, key_in};
                cs_n <= cs_sel;
                mosi <= msg_in[32*NB-1];
                ph <= '0;
                bits <= '0;
            end
            if (shifting) begin
                ph <= bit_end ? '0 : ph + 1'b1;
                if (bit_end) bits <= nxt != state ? '0 : bits + 1'b1;
            end
            if ((state == TX || state == RX) && rise) sclk <= 1'b1;
            if (bit_end) sclk <= 1'b0;
            if (state == TX && bit_end) begin
                piso <= piso << 1;
                mosi <= !last_bit && piso[TXB-2];
            end
            if (state == RX && rise) sipo <= {sipo[RXB-2:0], miso};
            if (state == RX && nxt == FINISH) begin
                result <= sipo;
                cs_n <= '1;
            end
        end
    end
endmodule
